// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers {instruction, pc+4} pairs across
// decode stalls, drops everything on flush, and shows a NOP bubble when empty.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_instruction,
  input  logic [WIDTH-1:0]             in_pc4,
  input  logic                         flush,
  input  logic                         stall,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_instruction,
  output logic [WIDTH-1:0]             out_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  localparam logic [WIDTH-1:0] NOP  = WIDTH'(32'h0000_0013);

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc4_mem   [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             enq;
  logic             deq;

  // Handshake is a function of registered count only; flush and stall gate the
  // internal transfer but never feed back into in_ready.
  always_comb begin
    in_ready  = (count != FULL);
    out_valid = (count != '0);
    enq       = in_valid && in_ready && !flush;
    deq       = out_valid && !stall && !flush;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; unread slots are never presented to decode.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc4_mem[wr_ptr]   <= in_pc4;
    end
  end

  always_comb begin
    out_instruction = NOP;
    out_pc4         = '0;
    if (out_valid) begin
      out_instruction = instr_mem[rd_ptr];
      out_pc4         = pc4_mem[rd_ptr];
    end
  end

endmodule
